// File: rtl/giraffe_pkg.sv
// giraffe_pkg: shared constants, state encodings and baud helper for the ADC test link UARTs.
//  CMD_HDR / OP_*   : command packet header byte and opcodes
//  rx_state_t       : byte receiver states (R_PARITY only with UART_PARITY_EN)
//  pkt_state_t      : command packet parser states
//  bit_cyc()        : clock cycles per UART bit
package giraffe_pkg;
  localparam logic [7:0] CMD_HDR    = 8'hA5;
  localparam logic [7:0] OP_START   = 8'h01;
  localparam logic [7:0] OP_SET_N   = 8'h02;
  localparam logic [7:0] OP_CALIB   = 8'h03;
  localparam logic [7:0] OP_SOFTRST = 8'h04;
  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
`ifdef UART_PARITY_EN
    R_PARITY,
`endif
    R_STOP
  } rx_state_t;
  typedef enum logic [2:0] {P_HDR, P_OP, P_AH, P_AL, P_SUM} pkt_state_t;
  function automatic int bit_cyc(input int freq, input int baud);
    return freq / baud;
  endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 2-FF synchronised UART byte receiver, 8N1 (8E1 when UART_PARITY_EN is defined).
//  clk_50M   in  system clock
//  nrst      in  async active-low reset
//  rx        in  asynchronous serial line, idle high
//  rdata     out last good byte
//  rvalid    out 1-cycle pulse, rdata updated
//  frame_err out 1-cycle pulse, bad stop bit or parity
module uart_rx
  import giraffe_pkg::*;
#(
  parameter int FREQ     = 50_000_000,
  parameter int BAUDRATE = 115200,
  parameter int N_data   = 8
) (
  input  logic       clk_50M,
  input  logic       nrst,
  input  logic       rx,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       frame_err
);
  localparam int BIT_CYC = bit_cyc(FREQ, BAUDRATE);
  localparam int HALF = BIT_CYC / 2;
  localparam int CW = $clog2(BIT_CYC + 1);
`ifdef UART_PARITY_EN
  localparam rx_state_t AFTER_DATA = R_PARITY;
`else
  localparam rx_state_t AFTER_DATA = R_STOP;
`endif
  rx_state_t state_q, state_d;
  logic [2:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, rdata_q, rdata_d;
  logic rvalid_q, rvalid_d, ferr_q, ferr_d;
  logic rxs, fall, tick_half, tick_bit, last_bit, stop_at, perr;
  assign rxs       = sync_q[1];
  assign fall      = sync_q[2] & ~sync_q[1];
  assign tick_half = cnt_q == CW'(HALF - 1);
  assign tick_bit  = cnt_q == CW'(BIT_CYC - 1);
  assign last_bit  = bit_q == 3'(N_data - 1);
  // after a bad stop bit the counter parks at BIT_CYC until the line returns high
  assign stop_at   = cnt_q >= CW'(BIT_CYC - 1);
`ifdef UART_PARITY_EN
  logic perr_q, perr_d;
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif
  always_ff @(posedge clk_50M or negedge nrst)
    if (!nrst) begin
      state_q  <= R_IDLE;
      sync_q   <= 3'b111;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ferr_q   <= ferr_d;
`ifdef UART_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      R_IDLE:   state_d = fall ? R_START : R_IDLE;
      R_START:  state_d = !tick_half ? R_START : rxs ? R_IDLE : R_DATA;
      R_DATA:   state_d = tick_bit && last_bit ? AFTER_DATA : R_DATA;
`ifdef UART_PARITY_EN
      R_PARITY: state_d = tick_bit ? R_STOP : R_PARITY;
`endif
      R_STOP:   state_d = stop_at && rxs ? R_IDLE : R_STOP;
      default:  state_d = R_IDLE;
    endcase
  end
  always_comb begin
    sync_d   = {sync_q[1:0], rx};
    cnt_d    = (state_q == R_IDLE || (state_q == R_START && tick_half) ||
                (state_q != R_STOP && tick_bit)) ? '0 :
               (state_q == R_STOP && cnt_q == CW'(BIT_CYC)) ? cnt_q : cnt_q + CW'(1);
    bit_d    = state_q == R_IDLE ? '0 : (state_q == R_DATA && tick_bit) ? bit_q + 3'd1 : bit_q;
    sh_d     = (state_q == R_DATA && tick_bit) ? {rxs, sh_q[7:1]} : sh_q;
    rvalid_d = state_q == R_STOP && tick_bit && rxs && !perr;
    ferr_d   = state_q == R_STOP && tick_bit && (!rxs || perr);
    rdata_d  = rvalid_d ? sh_q : rdata_q;
`ifdef UART_PARITY_EN
    perr_d   = state_q == R_IDLE ? 1'b0 :
               (state_q == R_PARITY && tick_bit) ? rxs ^ (^sh_q) : perr_q;
`endif
  end
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign frame_err = ferr_q;
endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART receiver plus 5-byte command decoder (A5 | OP | ARG_H | ARG_L | OP^ARG_H^ARG_L).
// Optional even parity framing with UART_PARITY_EN.
//  clk_50M     in  system clock
//  nrst        in  async active-low reset
//  rx          in  UART line from PC
//  rdata       out last received byte          rvalid    out byte pulse
//  frame_err   out framing/parity error pulse  cmd_start out START pulse
//  cmd_softrst out SOFTRST pulse               calib_ena out CALIB level
//  num_sampled out SET_N level                 cmd_err   out command error pulse
//  busy        out packet partially received
module uart_cmd_rx
  import giraffe_pkg::*;
#(
  parameter int BAUDRATE      = 115200,
  parameter int FREQ          = 50_000_000,
  parameter int N_data        = 8,
  parameter int NUM_SAMP_DEF  = 4096,
  parameter int NUM_SAMP_MAX  = 4096,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic        clk_50M,
  input  logic        nrst,
  input  logic        rx,
  output logic [7:0]  rdata,
  output logic        rvalid,
  output logic        frame_err,
  output logic        cmd_start,
  output logic        cmd_softrst,
  output logic        calib_ena,
  output logic [15:0] num_sampled,
  output logic        cmd_err,
  output logic        busy
);
  localparam int TMO = TIMEOUT_BYTES * 10 * bit_cyc(FREQ, BAUDRATE);
  localparam int TW = $clog2(TMO + 1);
  logic [7:0] rx_byte;
  logic rx_vld, rx_ferr;
  uart_rx #(.FREQ(FREQ), .BAUDRATE(BAUDRATE), .N_data(N_data)) u_rx (
    .clk_50M,
    .nrst,
    .rx,
    .rdata(rx_byte),
    .rvalid(rx_vld),
    .frame_err(rx_ferr)
  );
  pkt_state_t state_q, state_d;
  logic [7:0] op_q, op_d, ah_q, ah_d, al_q, al_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0] num_q, num_d, arg;
  logic calib_q, calib_d, start_q, start_d, soft_q, soft_d, err_q, err_d;
  logic in_pkt, tmo_hit, ferr_abort, sum_ev, sum_ok, exec, set_ok, op_ok;
  assign in_pkt     = state_q != P_HDR;
  // a byte arriving or a framing abort in the same cycle wins over the timeout
  assign tmo_hit    = in_pkt && !rx_vld && !rx_ferr && tmo_q == TW'(TMO - 1);
  assign ferr_abort = in_pkt && rx_ferr;
  assign sum_ev     = state_q == P_SUM && rx_vld;
  assign sum_ok     = rx_byte == (op_q ^ ah_q ^ al_q);
  assign exec       = sum_ev && sum_ok;
  assign arg        = {ah_q, al_q};
  assign set_ok     = arg != 16'd0 && arg <= 16'(NUM_SAMP_MAX);
  assign op_ok      = op_q inside {OP_START, OP_SOFTRST, OP_CALIB} || (op_q == OP_SET_N && set_ok);
  always_ff @(posedge clk_50M or negedge nrst)
    if (!nrst) begin
      state_q <= P_HDR;
      op_q    <= '0;
      ah_q    <= '0;
      al_q    <= '0;
      tmo_q   <= '0;
      num_q   <= 16'(NUM_SAMP_DEF);
      calib_q <= 1'b0;
      start_q <= 1'b0;
      soft_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ah_q    <= ah_d;
      al_q    <= al_d;
      tmo_q   <= tmo_d;
      num_q   <= num_d;
      calib_q <= calib_d;
      start_q <= start_d;
      soft_q  <= soft_d;
      err_q   <= err_d;
    end
  always_comb begin
    state_d = state_q;
    if (ferr_abort || tmo_hit) state_d = P_HDR;
    else if (rx_vld)
      case (state_q)
        P_HDR:   state_d = rx_byte == CMD_HDR ? P_OP : P_HDR;
        P_OP:    state_d = P_AH;
        P_AH:    state_d = P_AL;
        P_AL:    state_d = P_SUM;
        default: state_d = P_HDR;
      endcase
  end
  always_comb begin
    op_d    = (state_q == P_OP && rx_vld) ? rx_byte : op_q;
    ah_d    = (state_q == P_AH && rx_vld) ? rx_byte : ah_q;
    al_d    = (state_q == P_AL && rx_vld) ? rx_byte : al_q;
    tmo_d   = (!in_pkt || rx_vld) ? '0 : tmo_q + TW'(1);
    start_d = exec && op_q == OP_START;
    soft_d  = exec && op_q == OP_SOFTRST;
    num_d   = (exec && op_q == OP_SET_N && set_ok) ? arg : num_q;
    calib_d = (exec && op_q == OP_CALIB) ? al_q[0] : calib_q;
    err_d   = tmo_hit || (sum_ev && !(sum_ok && op_ok));
  end
  assign rdata       = rx_byte;
  assign rvalid      = rx_vld;
  assign frame_err   = rx_ferr;
  assign cmd_start   = start_q;
  assign cmd_softrst = soft_q;
  assign calib_ena   = calib_q;
  assign num_sampled = num_q;
  // a framing error inside a packet is reported in the same cycle it is seen
  assign cmd_err     = err_q | ferr_abort;
  assign busy        = in_pkt;
endmodule
